// File: rtl/map_ss_seq_if.sv
// map_ss_seq_if: host command, mapper save-state port and state-buffer signals of the sequencer
interface map_ss_seq_if;
    logic       cmd_save;
    logic       cmd_load;
    logic       busy;
    logic       done;
    logic       err;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdat;
    logic [7:0] mem_rdat;
    modport master (
        input  cmd_save, cmd_load, ss_rdat, mem_rdat,
        output busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_we, mem_wdat
    );
    modport slave (
        output cmd_save, cmd_load, ss_rdat, mem_rdat,
        input  busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_we, mem_wdat
    );
endinterface

// File: rtl/map_ss_seq.sv
// map_ss_seq: walks a mapper's save-state window, copying registers to a byte buffer (save)
// or restoring them after checking the stored mapper id (load).
module map_ss_seq #(
    parameter int         REG_CNT = 3,
    parameter logic [7:0] MAP_IDX = 8'd58,
    parameter int         SETTLE  = 2
) (
    input  logic         clk,
    input  logic         map_rst,
    map_ss_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, SV_ADDR, SV_CAP, LD_IDRD, LD_IDCHK, LD_RD, LD_WR, DONE} state_t;
    localparam logic [7:0] LAST  = 8'(REG_CNT - 1);
    localparam logic [7:0] ID_IX = 8'd127;
    localparam logic [2:0] SLAST = 3'(SETTLE - 1);
    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d, idx_nx;
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    // the id slot follows the last mapper register directly
    assign idx_nx = idx_q == LAST ? ID_IX : idx_q + 8'd1;
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        bus.busy     = state_q != IDLE;
        bus.done     = state_q == DONE;
        bus.err      = err_q;
        bus.ss_act   = state_q != IDLE && state_q != DONE;
        bus.ss_we    = 1'b0;
        bus.ss_addr  = '0;
        bus.ss_wdat  = '0;
        bus.mem_addr = '0;
        bus.mem_we   = 1'b0;
        bus.mem_wdat = '0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_save) begin
                    state_d = SV_ADDR;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (bus.cmd_load) begin
                    state_d = LD_IDRD;
                    err_d   = 1'b0;
                end
            end
            SV_ADDR: begin
                bus.ss_addr = idx_q;
                cnt_d       = cnt_q == SLAST ? 3'd0 : cnt_q + 3'd1;
                state_d     = cnt_q == SLAST ? SV_CAP : SV_ADDR;
            end
            SV_CAP: begin
                bus.ss_addr  = idx_q;
                bus.mem_we   = 1'b1;
                bus.mem_addr = idx_q;
                bus.mem_wdat = bus.ss_rdat;
                state_d      = idx_q == ID_IX ? DONE : SV_ADDR;
                idx_d        = idx_q == ID_IX ? idx_q : idx_nx;
            end
            LD_IDRD: begin
                bus.mem_addr = ID_IX;
                state_d      = LD_IDCHK;
            end
            LD_IDCHK: begin
                bus.mem_addr = ID_IX;
                err_d        = bus.mem_rdat != MAP_IDX;
                state_d      = bus.mem_rdat != MAP_IDX ? DONE : LD_RD;
                idx_d        = '0;
            end
            LD_RD: begin
                bus.mem_addr = idx_q;
                state_d      = LD_WR;
            end
            LD_WR: begin
                bus.mem_addr = idx_q;
                bus.ss_addr  = idx_q;
                bus.ss_wdat  = bus.mem_rdat;
                bus.ss_we    = 1'b1;
                state_d      = idx_q == LAST ? DONE : LD_RD;
                idx_d        = idx_q == LAST ? idx_q : idx_nx;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_map_ss_seq.sv
// tb_map_ss_seq: scoreboard bench for the save-state sequencer, two instances
// (REG_CNT=3/SETTLE=2 and REG_CNT=1/SETTLE=1) with a mapper readback model and a state buffer.
module tb_map_ss_seq;
    logic clk = 1'b0;
    logic map_rst = 1'b1;
    always #5 clk = ~clk;
    map_ss_seq_if i0 ();
    map_ss_seq_if i1 ();
    map_ss_seq #(.REG_CNT(3), .MAP_IDX(8'd58), .SETTLE(2)) u0 (.clk(clk), .map_rst(map_rst), .bus(i0.master));
    map_ss_seq #(.REG_CNT(1), .MAP_IDX(8'd58), .SETTLE(1)) u1 (.clk(clk), .map_rst(map_rst), .bus(i1.master));
    // mapper registers read back 05,03,01,... and the id 58 at index 127
    function automatic logic [7:0] mrd(input logic [7:0] a);
        return a == 8'd127 ? 8'd58 : 8'h05 - {a[6:0], 1'b0};
    endfunction
    assign i0.ss_rdat  = mrd(i0.ss_addr);
    assign i1.ss_rdat  = mrd(i1.ss_addr);
    assign i1.mem_rdat = 8'h00;
    logic [7:0] buf0 [128];
    logic       pk = 1'b0;
    logic [7:0] pk_d = 8'h00;
    always @(posedge clk) begin
        if (i0.mem_we) buf0[i0.mem_addr] <= i0.mem_wdat;
        else if (pk) buf0[127] <= pk_d;
        i0.mem_rdat <= buf0[i0.mem_addr];
    end
    logic [16:0] q0[$];
    logic [16:0] q1[$];
    int vec = 0, errs = 0, done0 = 0, done1 = 0, we0 = 0, wep0 = 0;
    logic we_prev0 = 1'b0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (i0.mem_we) chk("u0_mem", {1'b0, i0.mem_addr, i0.mem_wdat}, q0.size() != 0 ? q0.pop_front() : 17'h1ffff);
        if (i0.ss_we) chk("u0_ss", {1'b1, i0.ss_addr, i0.ss_wdat}, q0.size() != 0 ? q0.pop_front() : 17'h1ffff);
        if (i1.mem_we) chk("u1_mem", {1'b0, i1.mem_addr, i1.mem_wdat}, q1.size() != 0 ? q1.pop_front() : 17'h1ffff);
        if (i1.ss_we) chk("u1_ss", {1'b1, i1.ss_addr, i1.ss_wdat}, 17'h1ffff);
        we0  += int'(i0.ss_we);
        wep0 += int'(i0.ss_we && !we_prev0);
        we_prev0 = i0.ss_we;
        done0 += int'(i0.done);
        done1 += int'(i1.done);
    end
    task automatic push_save0();
        q0.push_back({1'b0, 8'd0, 8'h05});
        q0.push_back({1'b0, 8'd1, 8'h03});
        q0.push_back({1'b0, 8'd2, 8'h01});
        q0.push_back({1'b0, 8'd127, 8'h3a});
    endtask
    task automatic push_load0();
        q0.push_back({1'b1, 8'd0, 8'h05});
        q0.push_back({1'b1, 8'd1, 8'h03});
        q0.push_back({1'b1, 8'd2, 8'h01});
    endtask
    task automatic poke_id(input logic [7:0] d);
        @(negedge clk);
        pk = 1'b1;
        pk_d = d;
        @(negedge clk);
        pk = 1'b0;
    endtask
    // returns the number of edges from acceptance to the first cycle with done (or to stop_k)
    task automatic run0(input logic s, input logic l, input int mid_k, input int stop_k, output int lat);
        int k;
        @(negedge clk);
        i0.cmd_save = s;
        i0.cmd_load = l;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) begin
                i0.cmd_save = 1'b0;
                i0.cmd_load = 1'b0;
                chk("busy_rise", i0.busy, 1);
                chk("act_rise", i0.ss_act, 1);
            end
            if (k == mid_k) i0.cmd_load = 1'b1;
            else if (k == mid_k + 1) i0.cmd_load = 1'b0;
            if (k == stop_k || i0.done) break;
        end
        lat = k - 1;
    endtask
    initial begin
        int lat, b_we, b_wep;
        i0.cmd_save = 1'b0;
        i0.cmd_load = 1'b0;
        i1.cmd_save = 1'b0;
        i1.cmd_load = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_flags", {i0.busy, i0.done, i0.err, i0.ss_act, i0.ss_we, i0.mem_we}, 0);
        chk("rst_data", {i0.ss_addr, i0.ss_wdat, i0.mem_addr, i0.mem_wdat}, 0);
        map_rst = 1'b0;
        push_save0();
        run0(1'b1, 1'b0, 0, 0, lat);
        chk("sv_lat", lat, 12);
        chk("sv_done_act", i0.ss_act, 0);
        chk("sv_err", i0.err, 0);
        @(negedge clk);
        chk("sv_idle", i0.busy, 0);
        chk("sv_done_n", done0, 1);
        chk("sv_q", q0.size(), 0);
        b_we = we0;
        b_wep = wep0;
        push_load0();
        run0(1'b0, 1'b1, 0, 0, lat);
        chk("ld_lat", lat, 8);
        chk("ld_err", i0.err, 0);
        @(negedge clk);
        chk("ld_we_cyc", we0 - b_we, 3);
        chk("ld_we_pulses", wep0 - b_wep, 3);
        chk("ld_done_n", done0, 2);
        chk("ld_q", q0.size(), 0);
        poke_id(8'h04);
        b_we = we0;
        run0(1'b0, 1'b1, 0, 0, lat);
        chk("id_lat", lat, 2);
        chk("id_err", i0.err, 1);
        repeat (5) @(negedge clk);
        chk("id_err_sticky", i0.err, 1);
        chk("id_act", i0.ss_act, 0);
        chk("id_no_we", we0 - b_we, 0);
        chk("id_done_n", done0, 3);
        poke_id(8'h3a);
        push_load0();
        run0(1'b0, 1'b1, 0, 6, lat);
        chk("rs_err_clr", i0.err, 0);
        chk("rs_wr1", {i0.ss_we, i0.ss_addr}, {1'b1, 8'd1});
        #2 map_rst = 1'b1;
        #1 chk("rs_async", {i0.ss_we, i0.ss_act, i0.busy, i0.done}, 0);
        chk("rs_left", q0.size(), 1);
        q0.delete();
        @(negedge clk);
        map_rst = 1'b0;
        @(negedge clk);
        chk("rs_no_done", done0, 3);
        push_save0();
        run0(1'b1, 1'b0, 0, 0, lat);
        chk("rs_sv_lat", lat, 12);
        @(negedge clk);
        chk("rs_sv_done_n", done0, 4);
        push_save0();
        b_we = we0;
        run0(1'b1, 1'b1, 5, 0, lat);
        chk("both_lat", lat, 12);
        repeat (20) @(negedge clk);
        chk("both_idle", i0.busy, 0);
        chk("both_done_n", done0, 5);
        chk("both_no_we", we0 - b_we, 0);
        chk("both_q", q0.size(), 0);
        q1.push_back({1'b0, 8'd0, 8'h05});
        q1.push_back({1'b0, 8'd127, 8'h3a});
        @(negedge clk);
        i1.cmd_save = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            i1.cmd_save = 1'b0;
            lat = k - 1;
            if (i1.done) break;
        end
        chk("u1_lat", lat, 4);
        @(negedge clk);
        chk("u1_done_n", done1, 1);
        chk("u1_q", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/map_ss_seq.md
Name: map_ss_seq

Overview:
Save-state sequencer for a single NES mapper core. On a host command it walks the mapper's save-state register window (indices 0..REG_CNT-1, plus index 127 for the mapper id) over the ss bus. A save copies each register into a byte-wide state buffer; a load restores the registers from that buffer after checking the stored mapper id. It sits between the host/menu controller and the mapper's ss_act/ss_we/ss_addr/ss_rdat/cpu_dat save-state port.

Parameters:
REG_CNT, 3, number of mapper state registers at ss indices 0..REG_CNT-1 (range 1..126)
MAP_IDX, 8'd58, mapper id expected at ss index 127
SETTLE, 2, clk cycles ss_addr is held before ss_rdat is sampled (range 1..7)

Ports:
clk  in  1  system clock
map_rst  in  1  reset, asynchronous, active-high
cmd_save  in  1  one-cycle start pulse for a save; ignored while busy
cmd_load  in  1  one-cycle start pulse for a load; ignored while busy
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at the end of a sequence
err  out  1  sticky id-mismatch flag; cleared by the next accepted command
ss_act  out  1  save-state window active
ss_we  out  1  register write strobe to the mapper
ss_addr  out  8  mapper state register index
ss_wdat  out  8  data to the mapper (drives cpu_dat while ss_act)
ss_rdat  in  8  mapper readback
mem_addr  out  8  state buffer address (equal to the ss index)
mem_we  out  1  state buffer write strobe
mem_wdat  out  8  state buffer write data
mem_rdat  in  8  state buffer read data, valid 1 cycle after mem_addr

Behaviour:
- Reset values: busy=0, done=0, err=0, ss_act=0, ss_we=0, ss_addr=0, ss_wdat=0, mem_addr=0, mem_we=0, mem_wdat=0. State returns to IDLE.
- Index sequence: 0, 1, …, REG_CNT-1, then 127. The last index is 127; after index REG_CNT-1 the next index is 127, not REG_CNT.
- IDLE:
  - cmd_save → SV_ADDR with idx=0 and err cleared.
  - cmd_load → LD_IDRD with err cleared.
  - If both pulses arrive in the same cycle, save wins.
  - busy and ss_act rise in the cycle after the accepting edge.
- SV_ADDR: ss_addr=idx; a counter runs SETTLE cycles, then → SV_CAP.
- SV_CAP (1 cycle): mem_we=1, mem_addr=idx, mem_wdat=ss_rdat.
  - idx==127 → DONE.
  - Otherwise idx advances and → SV_ADDR.
  - Save latency: (REG_CNT+1)*(SETTLE+1) cycles from acceptance to DONE.
- LD_IDRD (1 cycle): mem_addr=127 → LD_IDCHK.
- LD_IDCHK:
  - mem_rdat != MAP_IDX → err=1, → DONE. No ss_we is ever asserted.
  - Match → LD_RD with idx=0.
- LD_RD (1 cycle): mem_addr=idx → LD_WR.
- LD_WR (1 cycle): ss_addr=idx, ss_wdat=mem_rdat, ss_we=1.
  - idx==REG_CNT-1 → DONE.
  - Otherwise idx advances and → LD_RD.
  - Index 127 is never written to the mapper.
  - ss_addr and ss_wdat are stable in the cycle ss_we is high.
- DONE (1 cycle): done=1, ss_act=0, ss_we=0; busy falls in the next cycle → IDLE.
- ss_act is high in every state except IDLE and DONE.
- mem_we and ss_we are never high in the same cycle.
- Commands arriving while busy or in DONE are dropped; there is no queueing.
- map_rst mid-sequence: all outputs return to reset values immediately (asynchronously).
  - No done pulse is issued.
  - Partially written buffer or mapper contents are left as-is.
  - err is cleared.
- Counter widths: idx is 8 bits; the SETTLE counter is 3 bits; there is no wrap beyond 127.

Test Plan:
- Save, REG_CNT=3, SETTLE=2, mapper readback {0:8'h05, 1:8'h03, 2:8'h01, 127:8'd58}, pulse cmd_save → mem writes (0,05), (1,03), (2,01), (127,3A) in that order; done asserted 12 cycles after acceptance; err=0.
- Load with buffer {05,03,01,…,127:3A} → exactly 3 ss_we pulses, writing (0,05), (1,03), (2,01); each ss_we one cycle long; done pulses once; err=0.
- Load with buffer[127]=8'h04 → err=1 and done pulse; zero ss_we pulses; ss_act low after DONE; err stays 1 until the next command.
- cmd_save and cmd_load in the same cycle → save sequence only; a cmd_load pulsed mid-save is ignored; no load occurs afterwards.
- map_rst asserted during LD_WR of idx=1 → ss_we, ss_act and busy go low before the next clk edge; no done; a new cmd_save after reset release completes normally.
- REG_CNT=1, SETTLE=1, save → mem writes at indices 0 and 127 only; done 4 cycles after acceptance.
